// File: rtl/code_programmer_pkg.sv
// Shared lock definitions: state encodings, combination length and the
// power-on combination used by the programmer, state_machine and decoder.
package code_programmer_pkg;

    localparam int              CP_NUM_DIGITS   = 6;
    localparam logic [23:0]     CP_DEFAULT_CODE = 24'h432731;

    localparam logic [3:0] ST_IDLE   = 4'b0000;
    localparam logic [3:0] ST_ENTER1 = 4'b0001;
    localparam logic [3:0] ST_ENTER2 = 4'b0010;
    localparam logic [3:0] ST_DONE   = 4'b0011;
    localparam logic [3:0] ST_FAIL   = 4'b0100;

    localparam logic [3:0] MAX_DIGIT = 4'd9;

endpackage

// File: rtl/code_programmer_if.sv
// Switch inputs and status outputs of the combination programmer.
interface code_programmer_if
    import code_programmer_pkg::*;
#(
    parameter int NUM_DIGITS = CP_NUM_DIGITS
);
    // SW[9] is a level-sensitive enable with no ready: while it is high, each
    // rising clock edge consumes SW[3:0] as one digit; dropping it aborts.
    logic [9:0]              SW;
    logic [4*NUM_DIGITS-1:0] code_out;
    logic [3:0]              present_state;
    logic [2:0]              digit_idx;
    logic                    busy;

    modport master (
        output SW,
        input  code_out,
        input  present_state,
        input  digit_idx,
        input  busy
    );

    modport slave (
        input  SW,
        output code_out,
        output present_state,
        output digit_idx,
        output busy
    );

endinterface

// File: rtl/code_programmer_code_store.sv
// Staging register for a combination being entered, plus per-slot comparison
// of the confirmation pass with a sticky mismatch flag.
module code_store #(
    parameter int NUM_DIGITS = 6,
    parameter int CODE_W     = 4 * NUM_DIGITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic              cmp_en,
    input  logic              clr_mismatch,
    input  logic [2:0]        slot,
    input  logic [3:0]        digit,
    output logic [CODE_W-1:0] staging,
    output logic              mismatch,
    output logic              mismatch_now
);

    logic [3:0] slot_val;
    logic       differs;

    // Slot 0 is the most significant nibble.
    always_comb begin
        slot_val = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot == 3'(i)) begin
                slot_val = staging[(NUM_DIGITS-1-i)*4 +: 4];
            end
        end
    end

    assign differs      = cmp_en && (digit != slot_val);
    assign mismatch_now = mismatch || differs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= '0;
        end else if (clear) begin
            staging <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (slot == 3'(i)) begin
                    staging[(NUM_DIGITS-1-i)*4 +: 4] <= digit;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
        end else if (clear || clr_mismatch) begin
            mismatch <= 1'b0;
        end else if (differs) begin
            mismatch <= 1'b1;
        end
    end

endmodule

// File: rtl/code_programmer.sv
// Combination programmer: a new code is entered twice on the switches and
// committed to code_out only when both passes agree digit for digit.
module code_programmer
    import code_programmer_pkg::*;
#(
    parameter int                      NUM_DIGITS   = CP_NUM_DIGITS,
    parameter logic [4*NUM_DIGITS-1:0] DEFAULT_CODE = CP_DEFAULT_CODE
) (
    input logic [3:0]         KEY,
    code_programmer_if.slave  bus
);

    localparam int CODE_W = 4 * NUM_DIGITS;

    logic clk;
    logic rst_n;
    assign clk   = KEY[0];
    assign rst_n = KEY[3];

    logic unused_inputs;
    assign unused_inputs = ^{KEY[2:1], bus.SW[8:4]};

    logic       enable;
    logic [3:0] digit;
    logic       digit_ok;
    assign enable   = bus.SW[9];
    assign digit    = bus.SW[3:0];
    assign digit_ok = (digit <= MAX_DIGIT);

    logic [3:0]        state, next_state;
    logic [2:0]        idx, next_idx;
    logic [CODE_W-1:0] code_q;
    logic              last_digit;
    logic              st_clear, st_wr, st_cmp, st_clr_mm, commit;
    logic [CODE_W-1:0] staging;
    logic              mismatch, mismatch_now;

    assign last_digit = (idx == 3'(NUM_DIGITS - 1));

    code_store #(
        .NUM_DIGITS (NUM_DIGITS),
        .CODE_W     (CODE_W)
    ) u_store (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (st_clear),
        .wr_en        (st_wr),
        .cmp_en       (st_cmp),
        .clr_mismatch (st_clr_mm),
        .slot         (idx),
        .digit        (digit),
        .staging      (staging),
        .mismatch     (mismatch),
        .mismatch_now (mismatch_now)
    );

    // Abort (enable low) outranks invalid digits and completion in every
    // active state, so it is tested first.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        st_clear   = 1'b0;
        st_wr      = 1'b0;
        st_cmp     = 1'b0;
        st_clr_mm  = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    next_state = ST_ENTER1;
                    next_idx   = '0;
                    st_clear   = 1'b1;
                end
            end
            ST_ENTER1: begin
                if (!enable) begin
                    next_state = ST_IDLE;
                    next_idx   = '0;
                end else if (!digit_ok) begin
                    next_state = ST_FAIL;
                    next_idx   = '0;
                end else begin
                    st_wr = 1'b1;
                    if (last_digit) begin
                        next_state = ST_ENTER2;
                        next_idx   = '0;
                        st_clr_mm  = 1'b1;
                    end else begin
                        next_idx = idx + 3'd1;
                    end
                end
            end
            ST_ENTER2: begin
                if (!enable) begin
                    next_state = ST_IDLE;
                    next_idx   = '0;
                end else if (!digit_ok) begin
                    next_state = ST_FAIL;
                    next_idx   = '0;
                end else begin
                    st_cmp = 1'b1;
                    if (last_digit) begin
                        next_idx = '0;
                        if (mismatch_now) begin
                            next_state = ST_FAIL;
                        end else begin
                            next_state = ST_DONE;
                            commit     = 1'b1;
                        end
                    end else begin
                        next_idx = idx + 3'd1;
                    end
                end
            end
            ST_DONE, ST_FAIL: begin
                next_idx = '0;
                if (!enable) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_idx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    // Staging is already complete on the final compare edge, so it commits as-is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= DEFAULT_CODE;
        end else if (commit) begin
            code_q <= staging;
        end
    end

    assign bus.code_out      = code_q;
    assign bus.present_state = state;
    assign bus.digit_idx     = idx;
    assign bus.busy          = (state != ST_IDLE);

endmodule
